// File: rtl/multi_powerup_timer.sv
// rtl/multi_powerup_timer.sv - shared-prescaler bank of independent power-up countdown channels
//
// Purpose:
//   N_CH countdown channels driven by one shared tick prescaler. A grant
//   loads or extends a channel. While a channel's count is non-zero it is
//   active, and each tick decrements it. When a channel runs out on a tick,
//   expired[i] pulses for one cycle.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-high; terminates everything silently
//   pause      - freezes prescaler phase and all channel counters
//   clear_all  - terminates all channels silently, zeroes prescaler
//   eaten      - single-cycle grant strobe for channel ch_sel
//   ch_sel     - channel targeted by the grant
//   dur        - grant duration in ticks (0 = ignored)
//   extend     - 1: add dur to a running channel (saturating); 0: reload
//   rd_sel     - channel selected for rd_remain
//   active     - per-channel running flag
//   warning    - per-channel "about to expire" flag (remain <= WARN_TICKS)
//   expired    - per-channel one-cycle pulse on natural expiry
//   rd_remain  - remaining ticks of channel rd_sel (combinational)

module multi_powerup_timer #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 4,
  parameter int PRESCALER  = 24999999,
  parameter int WARN_TICKS = 2,
  localparam int SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic             clear_all,
  input  logic             eaten,
  input  logic [SEL_W-1:0] ch_sel,
  input  logic [CNT_W-1:0] dur,
  input  logic             extend,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [N_CH-1:0]  active,
  output logic [N_CH-1:0]  warning,
  output logic [N_CH-1:0]  expired,
  output logic [CNT_W-1:0] rd_remain
);

  localparam int PS_W = (PRESCALER > 0) ? $clog2(PRESCALER + 1) : 1;

  logic [PS_W-1:0]  ps_cnt;
  logic             tick;
  logic             grant_ok;
  logic [CNT_W-1:0] remain     [N_CH];
  logic [CNT_W-1:0] remain_nxt [N_CH];
  logic [N_CH-1:0]  expire_nxt;
  logic [CNT_W:0]   sum;

  // Tick only fires while running; a paused prescaler holds its phase so
  // the tick cadence resumes exactly where it stopped.
  assign tick = !pause && (ps_cnt == PS_W'(PRESCALER));

  always_ff @(posedge clk) begin
    if (reset || clear_all) begin
      ps_cnt <= '0;
    end else if (!pause) begin
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
    end
  end

  // Out-of-range channel selects never match any channel index below, so
  // they fall out naturally as ignored grants.
  assign grant_ok = eaten && (dur != '0);

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_CH; i++) begin
      remain_nxt[i] = remain[i];
      expire_nxt[i] = 1'b0;
      if (grant_ok && (int'(ch_sel) == i)) begin
        // Grant beats a coincident tick for this channel.
        if (extend && (remain[i] != '0)) begin
          sum = {1'b0, remain[i]} + {1'b0, dur};
          // The carry bit is set exactly when the true sum exceeds the
          // counter range, so it selects saturation.
          remain_nxt[i] = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        end else begin
          remain_nxt[i] = dur;
        end
      end else if (tick && (remain[i] != '0)) begin
        remain_nxt[i] = remain[i] - 1'b1;
        expire_nxt[i] = (remain[i] == CNT_W'(1));
      end
    end
  end

  // Reset and clear_all drop every counter without reporting expiry.
  always_ff @(posedge clk) begin
    if (reset || clear_all) begin
      for (int i = 0; i < N_CH; i++) begin
        remain[i] <= '0;
      end
      expired <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        remain[i] <= remain_nxt[i];
      end
      expired <= expire_nxt;
    end
  end

  always_comb begin
    active    = '0;
    warning   = '0;
    rd_remain = '0;
    for (int i = 0; i < N_CH; i++) begin
      active[i]  = (remain[i] != '0);
      warning[i] = (remain[i] != '0) && (int'(remain[i]) <= WARN_TICKS);
      if (int'(rd_sel) == i) begin
        rd_remain = remain[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_powerup_timer.sv
// tb/tb_multi_powerup_timer.sv - self-checking bench for multi_powerup_timer

module tb_multi_powerup_timer;

  localparam int N_CH = 4;
  localparam int CNT_W = 4;
  localparam int PRESCALER = 3;
  localparam int WARN_TICKS = 2;
  localparam int MAXV = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pause = 1'b0;
  logic clear_all = 1'b0;
  logic eaten = 1'b0;
  logic [1:0] ch_sel = '0;
  logic [CNT_W-1:0] dur = '0;
  logic extend = 1'b0;
  logic [1:0] rd_sel = '0;
  logic [N_CH-1:0] active, warning, expired;
  logic [CNT_W-1:0] rd_remain;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model state: remaining ticks per channel, prescaler phase,
  // and the expiry pulses that follow the most recent edge.
  int m_rem[N_CH];
  int m_phase = 0;
  bit m_exp[N_CH];

  multi_powerup_timer #(
    .N_CH(N_CH), .CNT_W(CNT_W), .PRESCALER(PRESCALER), .WARN_TICKS(WARN_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .pause(pause), .clear_all(clear_all),
    .eaten(eaten), .ch_sel(ch_sel), .dur(dur), .extend(extend),
    .rd_sel(rd_sel), .active(active), .warning(warning),
    .expired(expired), .rd_remain(rd_remain)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Applies the rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit tk;
    int g;
    if (reset || clear_all) begin
      foreach (m_rem[i]) begin
        m_rem[i] = 0;
        m_exp[i] = 0;
      end
      m_phase = 0;
    end else begin
      tk = !pause && (m_phase == PRESCALER);
      g = (eaten && dur != 0 && int'(ch_sel) < N_CH) ? int'(ch_sel) : -1;
      foreach (m_rem[i]) begin
        m_exp[i] = 0;
        if (i == g) begin
          if (extend && m_rem[i] > 0)
            m_rem[i] = (m_rem[i] + int'(dur) > MAXV) ? MAXV : m_rem[i] + int'(dur);
          else
            m_rem[i] = int'(dur);
        end else if (tk && m_rem[i] > 0) begin
          m_rem[i] = m_rem[i] - 1;
          m_exp[i] = (m_rem[i] == 0);
        end
      end
      if (!pause) m_phase = (m_phase + 1) % (PRESCALER + 1);
    end
  endtask

  task automatic check_all();
    logic [N_CH-1:0] ea, ew, ee;
    foreach (m_rem[i]) begin
      ea[i] = (m_rem[i] != 0);
      ew[i] = (m_rem[i] != 0) && (m_rem[i] <= WARN_TICKS);
      ee[i] = m_exp[i];
    end
    chk("model_active", 32'(active), 32'(ea));
    chk("model_warning", 32'(warning), 32'(ew));
    chk("model_expired", 32'(expired), 32'(ee));
    chk("model_rd_remain", 32'(rd_remain), 32'(m_rem[rd_sel]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic grant(input int ch, input int d, input bit ext);
    eaten = 1'b1;
    ch_sel = 2'(ch);
    dur = CNT_W'(d);
    extend = ext;
    step();
    eaten = 1'b0;
    extend = 1'b0;
  endtask

  initial begin
    bit seen;

    // Reset state
    reset = 1'b1;
    step();
    step();
    chk("reset_active", 32'(active), 0);
    chk("reset_warning", 32'(warning), 0);
    chk("reset_expired", 32'(expired), 0);
    reset = 1'b0;

    // Basic countdown of ch2 with warning and expiry
    rd_sel = 2'd2;
    grant(2, 3, 1'b0);
    chk("r032_active_next", 32'(active[2]), 1);
    chk("r032_remain", 32'(rd_remain), 3);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (expired[2]) begin
        seen = 1;
        chk("r032_active_falls", 32'(active[2]), 0);
      end
    end
    chk("r032_expire_seen", 32'(seen), 1);
    step();
    chk("r032_pulse_one_cycle", 32'(expired[2]), 0);

    // Saturating extend, then reload
    rd_sel = 2'd0;
    grant(0, 14, 1'b0);
    grant(0, 5, 1'b1);
    chk("r033_saturate", 32'(rd_remain), MAXV);
    grant(0, 5, 1'b0);
    chk("r033_reload", 32'(rd_remain), 5);
    chk("r033_no_expire", 32'(expired), 0);

    // Pause holds counters and prescaler phase
    clear_all = 1'b1;
    step();
    clear_all = 1'b0;
    rd_sel = 2'd1;
    grant(1, 2, 1'b0);
    pause = 1'b1;
    for (int k = 0; k < 20; k++) step();
    chk("r034_held", 32'(rd_remain), 2);
    pause = 1'b0;
    seen = 0;
    for (int k = 0; k < 3 * (PRESCALER + 1) && !seen; k++) begin
      step();
      seen = expired[1];
    end
    chk("r034_expire_after_release", 32'(seen), 1);

    // Grant on the tick edge while another channel expires
    grant(0, 1, 1'b0);
    for (int k = 0; k < 8 && m_phase != PRESCALER; k++) step();
    rd_sel = 2'd3;
    grant(3, 4, 1'b0);
    chk("r035_grant_wins", 32'(rd_remain), 4);
    chk("r035_ch0_expired", 32'(expired[0]), 1);
    chk("r035_ch0_inactive", 32'(active[0]), 0);

    // clear_all with coincident grant, then reset mid-run
    for (int c = 0; c < N_CH; c++) grant(c, 9, 1'b0);
    clear_all = 1'b1;
    eaten = 1'b1; ch_sel = 2'd1; dur = 4'd7;
    step();
    clear_all = 1'b0; eaten = 1'b0;
    chk("r036_clear_active", 32'(active), 0);
    chk("r036_clear_expired", 32'(expired), 0);
    for (int c = 0; c < N_CH; c++) grant(c, 9, 1'b0);
    step();
    reset = 1'b1;
    eaten = 1'b1; ch_sel = 2'd2; dur = 4'd5;
    step();
    reset = 1'b0; eaten = 1'b0;
    chk("r036_reset_active", 32'(active), 0);
    chk("r036_reset_warning", 32'(warning), 0);
    step();
    chk("r036_reset_no_pulse", 32'(expired), 0);

    // Zero-duration grant is ignored
    rd_sel = 2'd1;
    grant(1, 6, 1'b0);
    pause = 1'b1;
    grant(1, 0, 1'b0);
    chk("r037_unchanged", 32'(rd_remain), 6);
    chk("r037_no_pulse", 32'(expired), 0);
    pause = 1'b0;

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      eaten = ($urandom_range(3) == 0);
      ch_sel = 2'($urandom_range(N_CH - 1));
      dur = CNT_W'($urandom_range(MAXV));
      extend = 1'($urandom_range(1));
      pause = ($urandom_range(7) == 0);
      clear_all = ($urandom_range(63) == 0);
      reset = ($urandom_range(127) == 0);
      rd_sel = 2'($urandom_range(N_CH - 1));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
